// File: rtl/byte_lane_data_memory.sv
// Word-organised data memory with byte/halfword lane access and a fixed wait-state latency.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned or reserved-size accesses via AddressError.
module byte_lane_data_memory #(
   parameter int ADDR_BITS   = 5,
   parameter int WAIT_STATES = 1
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        Request,
   input  logic        EnableWrite,
   input  logic [1:0]  Size,
   input  logic        SignExtend,
   input  logic [31:0] Address,
   input  logic [31:0] DataIn,
   output logic        Ready,
   output logic        Done,
   output logic [31:0] DataOut,
   output logic        AddressError
);

   localparam int DEPTH = 1 << ADDR_BITS;

   typedef enum logic {IDLE, BUSY} state_t;

   function automatic logic [DEPTH-1:0][31:0] init_mem();
      logic [DEPTH-1:0][31:0] m;
      for (int i = 0; i < DEPTH; i++) m[i] = 32'(i * 4);
      return m;
   endfunction

   // NOTE: the memory array takes its contents at time zero only; Reset never clears it,
   // so it has no reset branch and lives in its own always_ff.
   logic [DEPTH-1:0][31:0] mem = init_mem();

   state_t      state;
   logic [3:0]  count;
   logic        cap_we;
   logic [1:0]  cap_size;
   logic        cap_sx;
   logic [31:0] cap_addr;
   logic [31:0] cap_din;

   logic                 op_we;
   logic [1:0]           op_size;
   logic [1:0]           eff_size;
   logic                 op_sx;
   logic [31:0]          op_addr;
   logic [31:0]          op_din;
   logic [ADDR_BITS-1:0] word_idx;
   logic [31:0]          cur_word;
   logic [31:0]          wr_word;
   logic [31:0]          load_result;
   logic [7:0]           lane_b;
   logic [15:0]          lane_h;
   logic                 misaligned;
   logic                 finish;
   logic                 do_write;
   logic                 unused_addr_bits;

   // With zero wait states the access completes on its own accept edge, so the
   // operands come straight from the inputs instead of the capture registers.
   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      op_we   = cap_we;
      op_size = cap_size;
      op_sx   = cap_sx;
      op_addr = cap_addr;
      op_din  = cap_din;
      if (state == IDLE) begin
         op_we   = EnableWrite;
         op_size = Size;
         op_sx   = SignExtend;
         op_addr = Address;
         op_din  = DataIn;
      end

      finish = ((state == IDLE) && Request && (WAIT_STATES == 0)) ||
               ((state == BUSY) && (count == 4'd1));

`ifdef DMEM_MISALIGN_TRAP_EN
      misaligned = ((op_size == 2'b01) && op_addr[0])            ||
                   ((op_size == 2'b10) && (op_addr[1:0] != 2'b00)) ||
                   (op_size == 2'b11);
      eff_size   = op_size;
`else
      misaligned = 1'b0;
      eff_size   = (op_size == 2'b11) ? 2'b10 : op_size;
`endif

      word_idx = op_addr[ADDR_BITS+1:2];
      cur_word = mem[word_idx];
      lane_b   = cur_word[{op_addr[1:0], 3'b000} +: 8];
      lane_h   = op_addr[1] ? cur_word[31:16] : cur_word[15:0];

      load_result = cur_word;
      wr_word     = op_din;
      case (eff_size)
         2'b00: begin
            load_result = {{24{op_sx & lane_b[7]}}, lane_b};
            wr_word     = cur_word;
            wr_word[{op_addr[1:0], 3'b000} +: 8] = op_din[7:0];
         end
         2'b01: begin
            load_result = {{16{op_sx & lane_h[15]}}, lane_h};
            wr_word     = cur_word;
            wr_word[{op_addr[1], 4'b0000} +: 16] = op_din[15:0];
         end
         default: ;
      endcase

      do_write = finish && op_we && !misaligned && !Reset;
   end

   assign unused_addr_bits = ^op_addr[31:ADDR_BITS+2];

   always_ff @(posedge Clock) begin
      if (do_write) mem[word_idx] <= wr_word;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state        <= IDLE;
         Ready        <= 1'b1;
         Done         <= 1'b0;
         DataOut      <= '0;
         AddressError <= 1'b0;
         count        <= '0;
      end else begin
         Done <= finish;
         if (finish) begin
            DataOut      <= (op_we || misaligned) ? 32'd0 : load_result;
            AddressError <= misaligned;
         end
         case (state)
            IDLE: begin
               if (Request) begin
                  cap_we   <= EnableWrite;
                  cap_size <= Size;
                  cap_sx   <= SignExtend;
                  cap_addr <= Address;
                  cap_din  <= DataIn;
                  if (WAIT_STATES != 0) begin
                     state <= BUSY;
                     Ready <= 1'b0;
                     count <= 4'(WAIT_STATES);
                  end
               end
            end
            BUSY: begin
               if (count == 4'd1) begin
                  state <= IDLE;
                  Ready <= 1'b1;
                  count <= '0;
               end else begin
                  count <= count - 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_byte_lane_data_memory.sv
// Directed bench for byte_lane_data_memory: a vector table on a WAIT_STATES=1 instance,
// plus reset-abort, reset-priority, pulse-width and zero-wait-state sequences.
module tb_byte_lane_data_memory;

   localparam bit TRAP =
`ifdef DMEM_MISALIGN_TRAP_EN
      1'b1;
`else
      1'b0;
`endif

   typedef struct {
      logic        we;
      logic [1:0]  size;
      logic        sx;
      logic [31:0] addr;
      logic [31:0] din;
      logic [31:0] exp_data;
      logic        exp_err;
   } vec_t;

   logic        Clock = 1'b0;
   logic        Reset;
   logic        Request;
   logic        req_z;
   logic        EnableWrite;
   logic [1:0]  Size;
   logic        SignExtend;
   logic [31:0] Address;
   logic [31:0] DataIn;
   logic        Ready, Done, AddressError;
   logic [31:0] DataOut;
   logic        rdy_z, done_z, err_z;
   logic [31:0] dout_z;

   int checks   = 0;
   int failures = 0;

   vec_t vecs[18];

   always #5 Clock = ~Clock;

   byte_lane_data_memory #(.ADDR_BITS(5), .WAIT_STATES(1)) dut (
      .Clock(Clock), .Reset(Reset), .Request(Request), .EnableWrite(EnableWrite),
      .Size(Size), .SignExtend(SignExtend), .Address(Address), .DataIn(DataIn),
      .Ready(Ready), .Done(Done), .DataOut(DataOut), .AddressError(AddressError)
   );

   byte_lane_data_memory #(.ADDR_BITS(5), .WAIT_STATES(0)) dut_z (
      .Clock(Clock), .Reset(Reset), .Request(req_z), .EnableWrite(EnableWrite),
      .Size(Size), .SignExtend(SignExtend), .Address(Address), .DataIn(DataIn),
      .Ready(rdy_z), .Done(done_z), .DataOut(dout_z), .AddressError(err_z)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Called on a falling edge; returns on the falling edge inside the Done cycle.
   task automatic access(input bit z, input vec_t v, output logic [31:0] d, output logic e,
                         output int lat, output logic rdy_first);
      d = '0; e = 1'b0; lat = 0; rdy_first = 1'bx;
      EnableWrite = v.we; Size = v.size; SignExtend = v.sx; Address = v.addr; DataIn = v.din;
      if (z) req_z = 1'b1; else Request = 1'b1;
      @(posedge Clock); #1;
      Request = 1'b0; req_z = 1'b0;
      EnableWrite = ~v.we; Size = ~v.size; SignExtend = ~v.sx;
      Address = 32'hFFFF_FFFF; DataIn = ~v.din;
      for (int n = 1; n <= 20; n++) begin
         @(negedge Clock);
         if (n == 1) rdy_first = z ? rdy_z : Ready;
         if (z ? done_z : Done) begin
            lat = n;
            d   = z ? dout_z : DataOut;
            e   = z ? err_z : AddressError;
            break;
         end
      end
   endtask

   initial begin
      logic [31:0] d;
      logic        e, r, seen;
      int          lat;
      vec_t        v;

      vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0C, 32'h0,        32'h0000000C, 1'b0};
      vecs[1]  = '{1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF1234, 32'h0,        1'b0};
      vecs[2]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0};
      vecs[3]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'h00000080, 1'b0};
      vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h12, 32'h0,        32'hFFFF80FF, 1'b0};
      vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h12, 32'h0,        32'h000080FF, 1'b0};
      vecs[6]  = '{1'b1, 2'b00, 1'b0, 32'h11, 32'h000000AB, 32'h0,        1'b0};
      vecs[7]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'h80FFAB34, 1'b0};
      vecs[8]  = '{1'b0, 2'b01, 1'b0, 32'h10, 32'h0,        32'h0000AB34, 1'b0};
      vecs[9]  = '{1'b0, 2'b00, 1'b1, 32'h10, 32'h0,        32'h00000034, 1'b0};
      vecs[10] = '{1'b1, 2'b01, 1'b0, 32'h16, 32'h1234CAFE, 32'h0,        1'b0};
      vecs[11] = '{1'b0, 2'b10, 1'b0, 32'h14, 32'h0,        32'hCAFE0014, 1'b0};
      vecs[12] = '{1'b0, 2'b10, 1'b0, 32'h06, 32'h0,        TRAP ? 32'h0 : 32'h4, TRAP};
      vecs[13] = '{1'b0, 2'b01, 1'b0, 32'h13, 32'h0,        TRAP ? 32'h0 : 32'h000080FF, TRAP};
      vecs[14] = '{1'b1, 2'b11, 1'b0, 32'h1A, 32'h11111111, 32'h0,        TRAP};
      vecs[15] = '{1'b0, 2'b10, 1'b0, 32'h18, 32'h0,        TRAP ? 32'h18 : 32'h11111111, 1'b0};
      vecs[16] = '{1'b0, 2'b10, 1'b0, 32'h84, 32'h0,        32'h00000004, 1'b0};
      vecs[17] = '{1'b0, 2'b00, 1'b1, 32'h7C, 32'h0,        32'h0000007C, 1'b0};

      Reset = 1'b1; Request = 1'b0; req_z = 1'b0;
      EnableWrite = 1'b0; Size = 2'b00; SignExtend = 1'b0; Address = '0; DataIn = '0;
      repeat (2) @(posedge Clock);
      @(negedge Clock);
      Reset = 1'b0;
      check("rst_ready",   32'(Ready),        32'd1);
      check("rst_done",    32'(Done),         32'd0);
      check("rst_dataout", DataOut,           32'd0);
      check("rst_err",     32'(AddressError), 32'd0);
      check("rst_ready_z", 32'(rdy_z),        32'd1);
      check("rst_done_z",  32'(done_z),       32'd0);

      for (int i = 0; i < 18; i++) begin
         access(1'b0, vecs[i], d, e, lat, r);
         check($sformatf("v%0d_data", i),    d,         vecs[i].exp_data);
         check($sformatf("v%0d_err", i),     32'(e),    32'(vecs[i].exp_err));
         check($sformatf("v%0d_latency", i), 32'(lat),  32'd2);
         check($sformatf("v%0d_busy", i),    32'(r),    32'd0);
      end

      @(negedge Clock);
      check("done_width", 32'(Done),  32'd0);
      check("idle_ready", 32'(Ready), 32'd1);

      // Reset during BUSY: the completion edge coincides with Reset, so nothing is written.
      EnableWrite = 1'b1; Size = 2'b10; SignExtend = 1'b0; Address = 32'h08; DataIn = 32'hDEADBEEF;
      Request = 1'b1;
      @(posedge Clock); #1;
      Request = 1'b0;
      @(negedge Clock);
      check("abort_busy", 32'(Ready), 32'd0);
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge Clock);
         if (Done) seen = 1'b1;
      end
      check("abort_no_done", 32'(seen),   32'd0);
      check("abort_ready",   32'(Ready),  32'd1);
      check("abort_dataout", DataOut,     32'd0);
      v = '{1'b0, 2'b10, 1'b0, 32'h08, 32'h0, 32'h0, 1'b0};
      access(1'b0, v, d, e, lat, r);
      check("abort_mem", d,         32'h00000008);
      check("abort_lat", 32'(lat),  32'd2);

      // Reset and Request together: the request must not be accepted.
      EnableWrite = 1'b1; Size = 2'b10; Address = 32'h20; DataIn = 32'h99999999;
      Reset = 1'b1; Request = 1'b1;
      @(posedge Clock); #1;
      @(negedge Clock);
      check("prio_ready", 32'(Ready), 32'd1);
      Reset = 1'b0; Request = 1'b0;
      seen = 1'b0;
      for (int n = 0; n < 3; n++) begin
         @(negedge Clock);
         if (Done) seen = 1'b1;
      end
      check("prio_no_done", 32'(seen), 32'd0);
      v = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0};
      access(1'b0, v, d, e, lat, r);
      check("prio_mem", d, 32'h00000020);

      // Zero wait states: Done in the cycle right after accept, back-to-back.
      v = '{1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 32'h0, 1'b0};
      access(1'b1, v, d, e, lat, r);
      check("z_wrap_data", d,        32'h00000004);
      check("z_wrap_lat",  32'(lat), 32'd1);
      check("z_ready",     32'(r),   32'd1);
      v = '{1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF55, 32'h0, 1'b0};
      access(1'b1, v, d, e, lat, r);
      check("z_store_data", d,        32'h0);
      check("z_store_lat",  32'(lat), 32'd1);
      v = '{1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0};
      access(1'b1, v, d, e, lat, r);
      check("z_load_data", d,        32'h00005520);
      check("z_load_lat",  32'(lat), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/byte_lane_data_memory.md
BYTE_LANE_DATA_MEMORY -- requirements
Module: byte_lane_data_memory

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 5: word-index width; depth = 2^ADDR_BITS 32-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 1, range 0..15: extra cycles before completion.
REQ-003 SHALL have port Clock  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port Reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port Request  input  1  access request, sampled only while Ready=1.
REQ-006 SHALL have port EnableWrite  input  1  1 = store, 0 = load.
REQ-007 SHALL have port Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved.
REQ-008 SHALL have port SignExtend  input  1  loads only: 1 sign-extend, 0 zero-extend.
REQ-009 SHALL have port Address  input  32  byte address.
REQ-010 SHALL have port DataIn  input  32  store data, right-justified.
REQ-011 SHALL have port Ready  output  1  block can accept a request this cycle.
REQ-012 SHALL have port Done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port DataOut  output  32  registered load result.
REQ-014 SHALL have port AddressError  output  1  completed access was rejected; valid with Done.

Function
REQ-015 SHALL accept a request on a rising edge where Request=1 and Ready=1, capturing EnableWrite, Size, SignExtend, Address and DataIn; later input changes SHALL NOT affect that access.
REQ-016 SHALL ignore Request while Ready=0; no queuing.
REQ-017 SHALL use FSM IDLE (Ready=1) and BUSY (Ready=0, wait counter loaded with WAIT_STATES at accept, decremented each cycle).
REQ-018 SHALL assert Done for exactly one cycle, the (WAIT_STATES+1)-th cycle after the accept edge; Ready SHALL be 1 in that cycle, so back-to-back accesses are accepted.
REQ-019 SHALL select word index Address[ADDR_BITS+1:2]; higher address bits ignored, access wraps modulo depth.
REQ-020 SHALL use little-endian lanes: Address[1:0]=0 selects bits 7:0; halfword Address[1]=0 selects bits 15:0.
REQ-021 Stores SHALL modify only the addressed byte/halfword lanes (from DataIn[7:0]/[15:0]) on the edge that raises Done.
REQ-022 Loads SHALL present the extracted lane, extended per SignExtend, on DataOut from the Done cycle, holding it until the next Done.
REQ-023 Stores SHALL drive DataOut to 0 on their Done.
REQ-024 Memory word i SHALL initialise to i*4 at time zero; Reset SHALL NOT clear memory.

Reset
REQ-025 After a Reset edge: state IDLE, Ready=1, Done=0, DataOut=0, AddressError=0, counter 0.
REQ-026 Reset mid-access SHALL abort it: no memory write, no Done pulse.
REQ-027 Reset SHALL have priority over a simultaneous Request.

Configuration
REQ-028 With DMEM_MISALIGN_TRAP_EN defined: halfword with Address[0]=1, word with Address[1:0]!=0, or Size=11 SHALL complete with normal latency, AddressError=1, DataOut=0, no memory write.
REQ-029 Without DMEM_MISALIGN_TRAP_EN: AddressError tied 0; halfword ignores Address[0], word ignores Address[1:0]; Size=11 treated as word.

Verification
REQ-030 Reset, WAIT_STATES=1, load word 0x0C -> Ready low 1 cycle, Done 2 cycles after accept, DataOut=0x0000000C.
REQ-031 Store word 0x80FF1234 at 0x10; signed load byte 0x13 -> 0xFFFFFF80; unsigned -> 0x00000080; signed halfword 0x12 -> 0xFFFF80FF.
REQ-032 Store byte 0x000000AB at 0x11 onto 0x80FF1234 -> load word 0x10 returns 0x80FFAB34.
REQ-033 Load word 0x06: with macro -> Done, AddressError=1, DataOut=0; without -> DataOut=0x00000004.
REQ-034 Store word 0xDEADBEEF at 0x08, Reset during BUSY -> no Done, Ready=1 after reset, load 0x08 returns 0x00000008.
REQ-035 ADDR_BITS=5, load word 0x84 -> wraps to word 1, DataOut=0x00000004; WAIT_STATES=0 -> Done the cycle after accept.
